// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared state, frame constants and checksum helper for the program loader
package boot_pkg;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHK,
    S_RUN,
    S_ERR
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_BITS      = 8 * BYTES_PER_WORD;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/boot_loader_word_assembler.sv
// rtl/boot_loader_word_assembler.sv - little-endian byte-to-word packer with word-complete strobe
module word_assembler
  import boot_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 word_done,
  output logic [WORD_BITS-1:0] word
);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0]     cnt;
  logic [WORD_BITS-9:0] sr;

  // The final byte is merged combinationally so the word is complete on the strobe cycle.
  assign word_done = byte_valid && (cnt == LAST_BYTE);
  assign word      = {byte_data, sr};

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      sr  <= '0;
    end else if (byte_valid) begin
      cnt <= cnt + 1'b1;
      sr  <= {byte_data, sr[WORD_BITS-9:8]};
    end
  end

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - host byte-stream program loader with length/checksum verify and CPU reset control
module boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  if (WORD_W != WORD_BITS) begin : g_word_w_check
    $error("boot_loader: WORD_W must be 32");
  end

  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

  state_t                state, state_n;
  logic [7:0]            len_lo;
  logic [15:0]           last_idx;
  logic [ADDR_W-1:0]     idx;
  logic [7:0]            acc;
  logic                  xfer;
  logic                  word_byte;
  logic                  word_done;
  logic [WORD_BITS-1:0]  word;
  logic [15:0]           n_len;
  logic                  last_word;

  assign in_ready  = rst && (state inside {S_LEN0, S_LEN1, S_DATA, S_CHK});
  assign xfer      = in_valid && in_ready;
  assign n_len     = {in_data, len_lo};
  assign last_word = ({{(32-ADDR_W){1'b0}}, idx} == {16'd0, last_idx});
  assign done      = (state == S_RUN);
  assign error     = (state == S_ERR);
  assign cpu_rst   = (state != S_RUN);

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(word_byte),
    .byte_data (in_data),
    .word_done (word_done),
    .word      (word)
  );

  always_comb begin
    state_n   = state;
    word_byte = 1'b0;
    case (state)
      S_LEN0: if (xfer) state_n = S_LEN1;
      S_LEN1: begin
        if (xfer) begin
          if (n_len == 16'd0)                  state_n = S_CHK;
          else if ({16'd0, n_len} > CAPACITY)  state_n = S_ERR;
          else                                 state_n = S_DATA;
        end
      end
      S_DATA: begin
        word_byte = xfer;
        if (word_done && last_word) state_n = S_CHK;
      end
      S_CHK: if (xfer) state_n = (in_data == acc) ? S_RUN : S_ERR;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_LEN0;
      len_lo     <= '0;
      last_idx   <= '0;
      idx        <= '0;
      acc        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state   <= state_n;
      imem_we <= word_done;
      // The checksum byte itself is compared, not accumulated.
      if (xfer && state != S_CHK)  acc      <= chk_update(acc, in_data);
      if (xfer && state == S_LEN0) len_lo   <= in_data;
      if (xfer && state == S_LEN1) last_idx <= n_len - 16'd1;
      if (word_done) begin
        imem_addr  <= idx;
        imem_wdata <= word;
        idx        <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - directed self-checking bench for boot_loader
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int base;
  logic [7:0]  wr_addr [64];
  logic [31:0] wr_data [64];

  always #5 clk = ~clk;

  boot_loader #(.ADDR_W(8), .WORD_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .error     (error)
  );

  always @(negedge clk) begin
    if (imem_we && wr_count < 64) begin
      wr_addr[wr_count] = imem_addr;
      wr_data[wr_count] = imem_wdata;
      wr_count++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int w;
    in_data  = b;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("ready_for_byte", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_nominal(input logic [7:0] chk, input int gap);
    logic [7:0] f [11];
    f = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h00};
    f[10] = chk;
    for (int i = 0; i < 11; i++) begin
      send(f[i]);
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    check({tag, "_addr"}, {24'd0, imem_addr}, 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic check_nominal_writes(input string tag, input int b);
    check({tag, "_wcount"}, wr_count - b, 32'd2);
    check({tag, "_addr0"}, {24'd0, wr_addr[b]}, 32'd0);
    check({tag, "_data0"}, wr_data[b], 32'h00500093);
    check({tag, "_addr1"}, {24'd0, wr_addr[b+1]}, 32'd1);
    check({tag, "_data1"}, wr_data[b+1], 32'h00100113);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Nominal load, stepwise with exact write-cycle checks
    base = wr_count;
    send(8'h02); send(8'h00); send(8'h93); send(8'h00); send(8'h50);
    send(8'h00);
    check("w0_we", {31'd0, imem_we}, 32'd1);
    check("w0_addr", {24'd0, imem_addr}, 32'd0);
    check("w0_data", imem_wdata, 32'h00500093);
    send(8'h13);
    check("w0_we_low", {31'd0, imem_we}, 32'd0);
    check("w0_data_hold", imem_wdata, 32'h00500093);
    send(8'h01); send(8'h10); send(8'h00);
    check("w1_we", {31'd0, imem_we}, 32'd1);
    check("w1_addr", {24'd0, imem_addr}, 32'd1);
    check("w1_data", imem_wdata, 32'h00100113);
    check("pre_chk_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    send(8'hC3);
    check("nom_done", {31'd0, done}, 32'd1);
    check("nom_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("nom_ready", {31'd0, in_ready}, 32'd0);
    check("nom_error", {31'd0, error}, 32'd0);
    check_nominal_writes("nom", base);

    // Bad checksum
    pulse_reset();
    base = wr_count;
    send_nominal(8'hC2, 0);
    repeat (3) @(posedge clk);
    #1;
    check("badchk_error", {31'd0, error}, 32'd1);
    check("badchk_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("badchk_ready", {31'd0, in_ready}, 32'd0);
    check("badchk_done", {31'd0, done}, 32'd0);
    check_nominal_writes("badchk", base);

    // Zero length, then zero length with a wrong checksum
    pulse_reset();
    base = wr_count;
    send(8'h00); send(8'h00); send(8'h00);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("zero_wcount", wr_count - base, 32'd0);
    pulse_reset();
    send(8'h00); send(8'h00); send(8'h01);
    check("zero_bad_error", {31'd0, error}, 32'd1);
    check("zero_bad_done", {31'd0, done}, 32'd0);

    // Oversize length 257, then the largest legal length 256
    pulse_reset();
    base = wr_count;
    send(8'h01); send(8'h01);
    check("over_error", {31'd0, error}, 32'd1);
    check("over_ready", {31'd0, in_ready}, 32'd0);
    check("over_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("over_wcount", wr_count - base, 32'd0);
    pulse_reset();
    send(8'h00); send(8'h01);
    check("max_len_error", {31'd0, error}, 32'd0);
    check("max_len_ready", {31'd0, in_ready}, 32'd1);

    // Stalled host
    pulse_reset();
    base = wr_count;
    send_nominal(8'hC3, 3);
    check("stall_done", {31'd0, done}, 32'd1);
    check("stall_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check_nominal_writes("stall", base);

    // Reset in the middle of word 0
    pulse_reset();
    base = wr_count;
    send(8'h02); send(8'h00); send(8'h93); send(8'h00); send(8'h50);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_wcount", wr_count - base, 32'd0);
    send_nominal(8'hC3, 0);
    check("midrst_done", {31'd0, done}, 32'd1);
    check_nominal_writes("midrst", base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

On-chip receiving end of the host program-load link: accepts a byte stream from the host over a valid/ready handshake and writes it into instruction memory. It holds the `CPU` core in reset during the load and releases it only after the length and checksum verify. It sits between the external host interface and the `CPU`'s `rst` input and instruction-memory write port.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory word-address width. Capacity is 2^ADDR_W words.
- `WORD_W`, 32: instruction word width. Fixed at 4 bytes; any other value is illegal.

Ports:
- `clk`  input  1: single clock; all logic is on the rising edge.
- `rst`  input  1: synchronous, active-low reset.
- `in_data`  input  8: host byte.
- `in_valid`  input  1: host byte valid.
- `in_ready`  output  1: loader can accept a byte.
- `imem_we`  output  1: instruction-memory write strobe, one-cycle pulse per word.
- `imem_addr`  output  ADDR_W: word address.
- `imem_wdata`  output  WORD_W: word data.
- `cpu_rst`  output  1: active-high reset to `CPU`.
- `done`  output  1: load verified and CPU released.
- `error`  output  1: load failed; sticky.

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N×4 data bytes (each word little-endian), then CHK.
- CHK = XOR of every preceding frame byte, including the length bytes.
- A byte transfers on a rising edge where `in_valid && in_ready`. The host must hold `in_data` stable while `in_valid` is high and `in_ready` is low.
- FSM states: LEN0, LEN1, DATA, CHK, RUN, ERR.
  - LEN0 -> LEN1 on transfer.
  - LEN1 -> DATA on transfer when 0 < N <= 2^ADDR_W.
  - LEN1 -> CHK on transfer when N == 0.
  - LEN1 -> ERR on transfer when N > 2^ADDR_W.
  - DATA: byte counter 0..3 shifts bytes into the word, LSB first. On the 4th byte the word is written. After the word with index N-1 -> CHK.
  - CHK -> RUN on transfer with matching checksum; -> ERR on mismatch.
  - RUN and ERR are terminal until `rst` is low.
- `in_ready` = `rst` && state ∈ {LEN0, LEN1, DATA, CHK}. It is a pure function of registered state, with no combinational path from `in_valid`.
- Word index starts at 0 and increments after each write. It must not wrap: N ≤ 2^ADDR_W is enforced by the LEN1 check.
- Running XOR is cleared on reset and updated on every accepted byte except CHK itself.

## Timing
- Reset values (cycle after `rst` sampled low, and held while low):
  - `cpu_rst`=1
  - `done`=0, `error`=0
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0
  - `in_ready`=0
  - state = LEN0, XOR = 0, counters = 0
- `in_ready` is high in the first cycle after `rst` is sampled high.
- Memory write: if the 4th byte of word k transfers at edge T, then `imem_we`=1, `imem_addr`=k and `imem_wdata`=the assembled word are valid for exactly the cycle after T. Address and data hold their values after the pulse.
- Release: if CHK transfers at edge T with a match, then from the cycle after T `cpu_rst`=0 and `done`=1. The last memory write precedes the release by at least one cycle.
- Mismatch or oversize N: from the cycle after the offending transfer, `error`=1, `cpu_rst` stays 1, and `in_ready`=0.
- Bubbles: `in_valid` low for any number of cycles stalls the FSM with no state change and no write.
- Reset mid-load: the frame is aborted and all registers return to reset values. Memory already written is left untouched, and the next byte is treated as LEN_LO.

## Structure
- Shared package `boot_pkg`: state enum, frame byte constants (`LEN_BYTES`=2, `BYTES_PER_WORD`=4), and the checksum function.
- Natural sub-module: `word_assembler` (byte counter, little-endian shift register, word-complete strobe). The FSM, length check, XOR and reset control stay in `boot_loader`.

## Test plan
- Nominal load: send 02 00 93 00 50 00 13 01 10 00 C3.
  - Writes: addr 0 = 0x00500093, then addr 1 = 0x00100113, each a one-cycle `imem_we`.
  - Then `done`=1 and `cpu_rst`=0.
- Bad checksum: same frame with CHK = C2.
  - Both words are written, then `error`=1, `cpu_rst`=1, and `in_ready`=0 permanently.
- Zero length: send 00 00 00.
  - No `imem_we`, then `done`=1.
  - A second frame with CHK 01 gives `error`=1.
- Oversize (ADDR_W=8): send 01 01.
  - `error`=1 the cycle after LEN_HI, with no writes.
- Stalled host: nominal frame with `in_valid` deasserted 3 cycles between every byte.
  - Identical writes and release; `imem_we` pulse count = 2.
- Reset mid-word: assert `rst`=0 for one cycle after 93 00 50.
  - All outputs return to reset values and no write occurs.
  - The nominal frame then loads correctly from addr 0.
